twophase_monitor: RTL and testbench

- Receive-side checker for a two-phase non-overlapping clock pair (PHI1/PHI2) generated elsewhere in the design.
- Oversamples both phases with a faster system clock and checks ordering and non-overlap.
- Measures high times and dead-time gaps in system-clock cycles, and reconstructs a single-phase clock.
- Sits beside the two-phase generator as a lab/bring-up monitor; results read out via status ports.

---
 rtl/twophase_monitor.sv | 185 ++++++++++++++++++
 tb/tb_twophase_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twophase_monitor.sv
// Receive-side monitor for a two-phase non-overlapping clock pair: checks ordering and overlap,
// measures phase high times and dead times, and rebuilds a single-phase clock.
module twophase_monitor #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MIN_GAP = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_phi1,
  input  logic             i_phi2,
  input  logic             i_clear_err,
  output logic             o_clk_rec,
  output logic             o_meas_valid,
  output logic [CNT_W-1:0] o_t_phi1,
  output logic [CNT_W-1:0] o_t_gap12,
  output logic [CNT_W-1:0] o_t_phi2,
  output logic [CNT_W-1:0] o_t_gap21,
  output logic             o_locked,
  output logic             o_overlap_err,
  output logic             o_seq_err,
  output logic             o_gap_err,
  output logic             o_stall_err
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MinGap = CNT_W'(MIN_GAP);

  typedef enum logic [2:0] {StSync, StArm, StP1, StGapB, StP2, StGapA} state_e;

  state_e           r_state, w_state_d;
  logic             r_phi1_meta, r_phi2_meta, r_s1, r_s2;
  logic [CNT_W-1:0] r_cnt, r_sh_t1, r_sh_g12, r_sh_t2;
  logic [CNT_W-1:0] r_t_phi1, r_t_gap12, r_t_phi2, r_t_gap21;
  logic             r_g12_bad, r_clk_rec, r_meas_valid, r_locked;
  logic             r_ovl_err, r_seq_err, r_gap_err, r_stall_err;

  logic             w_active, w_cap_t1, w_cap_g12, w_cap_t2, w_pulse;
  logic             w_ovl, w_seq, w_stall, w_g12_bad, w_g21_bad, w_gap_ev, w_err_ev;
  logic [CNT_W-1:0] w_g12_val, w_g21_val;

  assign w_active = (r_state == StP1) || (r_state == StGapB) ||
                    (r_state == StP2) || (r_state == StGapA);

  always_comb begin
    w_state_d = r_state;
    w_cap_t1  = 1'b0;
    w_cap_g12 = 1'b0;
    w_cap_t2  = 1'b0;
    w_pulse   = 1'b0;
    w_ovl     = 1'b0;
    w_seq     = 1'b0;
    w_stall   = 1'b0;
    w_g12_val = r_cnt;
    w_g21_val = r_cnt;
    // Overlap beats saturation, which beats every ordinary transition.
    if (w_active && r_s1 && r_s2) begin
      w_ovl     = 1'b1;
      w_state_d = StSync;
    end else if (w_active && (r_cnt == CntMax)) begin
      w_stall   = 1'b1;
      w_state_d = StSync;
    end else begin
      unique case (r_state)
        StSync: if (!r_s1 && !r_s2) w_state_d = StArm;
        StArm:  if (r_s1 && !r_s2) w_state_d = StP1;
        StP1: begin
          if (!r_s1) begin
            w_cap_t1 = 1'b1;
            if (r_s2) begin
              w_state_d = StP2;
              w_cap_g12 = 1'b1;
              w_g12_val = '0;
            end else begin
              w_state_d = StGapB;
            end
          end
        end
        StGapB: begin
          if (r_s2) begin
            w_state_d = StP2;
            w_cap_g12 = 1'b1;
          end else if (r_s1) begin
            w_seq     = 1'b1;
            w_state_d = StSync;
          end
        end
        StP2: begin
          if (!r_s2) begin
            w_cap_t2 = 1'b1;
            if (r_s1) begin
              w_state_d = StP1;
              w_pulse   = 1'b1;
              w_g21_val = '0;
            end else begin
              w_state_d = StGapA;
            end
          end
        end
        StGapA: begin
          if (r_s1) begin
            w_state_d = StP1;
            w_pulse   = 1'b1;
          end else if (r_s2) begin
            w_seq     = 1'b1;
            w_state_d = StSync;
          end
        end
        default: w_state_d = StSync;
      endcase
    end
  end

  assign w_g12_bad = w_cap_g12 && (w_g12_val < MinGap);
  assign w_g21_bad = w_pulse && (w_g21_val < MinGap);
  assign w_gap_ev  = w_g12_bad || w_g21_bad;
  assign w_err_ev  = w_ovl || w_seq || w_stall || w_gap_ev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phi1_meta  <= 1'b0;
      r_phi2_meta  <= 1'b0;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_state      <= StSync;
      r_cnt        <= '0;
      r_sh_t1      <= '0;
      r_sh_g12     <= '0;
      r_sh_t2      <= '0;
      r_g12_bad    <= 1'b0;
      r_t_phi1     <= '0;
      r_t_gap12    <= '0;
      r_t_phi2     <= '0;
      r_t_gap21    <= '0;
      r_meas_valid <= 1'b0;
      r_clk_rec    <= 1'b0;
      r_locked     <= 1'b0;
      r_ovl_err    <= 1'b0;
      r_seq_err    <= 1'b0;
      r_gap_err    <= 1'b0;
      r_stall_err  <= 1'b0;
    end else begin
      r_phi1_meta <= i_phi1;
      r_phi2_meta <= i_phi2;
      r_s1        <= r_phi1_meta;
      r_s2        <= r_phi2_meta;
      r_state     <= w_state_d;
      if (w_state_d != r_state) r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (r_cnt != CntMax) r_cnt <= r_cnt + 1'b1;
      if (w_cap_t1) r_sh_t1 <= r_cnt;
      if (w_cap_g12) begin
        r_sh_g12  <= w_g12_val;
        r_g12_bad <= w_g12_bad;
      end
      if (w_cap_t2) r_sh_t2 <= r_cnt;
      // The closing capture of a period lands directly in the outputs.
      if (w_pulse) begin
        r_t_phi1  <= r_sh_t1;
        r_t_gap12 <= r_sh_g12;
        r_t_phi2  <= w_cap_t2 ? r_cnt : r_sh_t2;
        r_t_gap21 <= w_g21_val;
      end
      r_meas_valid <= w_pulse;
      r_clk_rec    <= (r_state == StP1) || (r_state == StGapB);
      if (w_err_ev) r_locked <= 1'b0;
      else if (w_pulse && !r_g12_bad) r_locked <= 1'b1;
      r_ovl_err   <= (r_ovl_err & ~i_clear_err) | w_ovl;
      r_seq_err   <= (r_seq_err & ~i_clear_err) | w_seq;
      r_gap_err   <= (r_gap_err & ~i_clear_err) | w_gap_ev;
      r_stall_err <= (r_stall_err & ~i_clear_err) | w_stall;
    end
  end

  assign o_clk_rec     = r_clk_rec;
  assign o_meas_valid  = r_meas_valid;
  assign o_t_phi1      = r_t_phi1;
  assign o_t_gap12     = r_t_gap12;
  assign o_t_phi2      = r_t_phi2;
  assign o_t_gap21     = r_t_gap21;
  assign o_locked      = r_locked;
  assign o_overlap_err = r_ovl_err;
  assign o_seq_err     = r_seq_err;
  assign o_gap_err     = r_gap_err;
  assign o_stall_err   = r_stall_err;

endmodule

// File: tb/tb_twophase_monitor.sv
// Directed bench for twophase_monitor: phases driven one sample per system clock,
// measurement pulses and reconstructed-clock edges logged on the falling edge.
module tb_twophase_monitor;

  logic       clk = 1'b0, rst_n = 1'b0, phi1 = 1'b0, phi2 = 1'b0, clear_err = 1'b0;
  logic       clk_rec, meas_valid, locked, ovl_err, seq_err, gap_err, stall_err;
  logic [7:0] t_phi1, t_gap12, t_phi2, t_gap21;

  int         tests = 0, fails = 0;
  int         cyc = 0, mv_cnt = 0, base = 0;
  logic [7:0] mv_t1 = '0, mv_g12 = '0, mv_t2 = '0, mv_g21 = '0;
  int         rise_prev = -1, rise_last = -1, fall_last = -1;
  logic       rec_prev = 1'b0;

  twophase_monitor #(.CNT_W(8), .MIN_GAP(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_phi1       (phi1),
    .i_phi2       (phi2),
    .i_clear_err  (clear_err),
    .o_clk_rec    (clk_rec),
    .o_meas_valid (meas_valid),
    .o_t_phi1     (t_phi1),
    .o_t_gap12    (t_gap12),
    .o_t_phi2     (t_phi2),
    .o_t_gap21    (t_gap21),
    .o_locked     (locked),
    .o_overlap_err(ovl_err),
    .o_seq_err    (seq_err),
    .o_gap_err    (gap_err),
    .o_stall_err  (stall_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (meas_valid === 1'b1) begin
      mv_cnt++;
      mv_t1  = t_phi1;
      mv_g12 = t_gap12;
      mv_t2  = t_phi2;
      mv_g21 = t_gap21;
    end
    if (clk_rec === 1'b1 && rec_prev !== 1'b1) begin
      rise_prev = rise_last;
      rise_last = cyc;
    end
    if (clk_rec !== 1'b1 && rec_prev === 1'b1) fall_last = cyc;
    rec_prev = clk_rec;
  end

  task automatic hold(input logic p1, input logic p2, input int n);
    phi1 = p1;
    phi2 = p2;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic period(input int t1, input int g12, input int t2, input int g21);
    hold(1'b1, 1'b0, t1);
    hold(1'b0, 1'b0, g12);
    hold(1'b0, 1'b1, t2);
    hold(1'b0, 1'b0, g21);
  endtask

  // Remainder of a 10/3/10/3 period after its first 5 PHI1 samples.
  task automatic finish_period();
    hold(1'b1, 1'b0, 5);
    hold(1'b0, 1'b0, 3);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 3);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({clk_rec, meas_valid, locked, ovl_err, seq_err, gap_err, stall_err} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {clk_rec, meas_valid, locked, ovl_err, seq_err, gap_err, stall_err});
    end
    tests++;
    if ({t_phi1, t_gap12, t_phi2, t_gap21} !== 32'h0) begin
      fails++;
      $display("FAIL reset_meas: got %h expected 0", {t_phi1, t_gap12, t_phi2, t_gap21});
    end
    rst_n = 1'b1;
    hold(1'b0, 1'b0, 4);
  endtask

  task automatic test_clean();
    base = mv_cnt;
    repeat (3) period(10, 3, 10, 3);
    tests++;
    if (mv_cnt - base !== 2) begin
      fails++;
      $display("FAIL clean_pulses: got %0d expected 2", mv_cnt - base);
    end
    tests++;
    if ({mv_t1, mv_g12, mv_t2, mv_g21} !== {8'd10, 8'd3, 8'd10, 8'd3}) begin
      fails++;
      $display("FAIL clean_meas: got %0d/%0d/%0d/%0d expected 10/3/10/3",
               mv_t1, mv_g12, mv_t2, mv_g21);
    end
    tests++;
    if ({locked, ovl_err, seq_err, gap_err, stall_err} !== 5'b10000) begin
      fails++;
      $display("FAIL clean_status: got %b expected 10000",
               {locked, ovl_err, seq_err, gap_err, stall_err});
    end
    tests++;
    if (rise_last - rise_prev !== 26) begin
      fails++;
      $display("FAIL clk_rec_period: got %0d expected 26", rise_last - rise_prev);
    end
    tests++;
    if (fall_last - rise_last !== 13) begin
      fails++;
      $display("FAIL clk_rec_high: got %0d expected 13", fall_last - rise_last);
    end
  endtask

  task automatic test_overlap();
    hold(1'b1, 1'b0, 4);
    base = mv_cnt;
    hold(1'b1, 1'b1, 1);
    hold(1'b1, 1'b0, 5);
    tests++;
    if ({ovl_err, locked} !== 2'b10) begin
      fails++;
      $display("FAIL overlap_flag: got ovl=%b locked=%b expected ovl=1 locked=0",
               ovl_err, locked);
    end
    hold(1'b0, 1'b0, 3);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 3);
    repeat (2) period(10, 3, 10, 3);
    tests++;
    if (mv_cnt - base !== 1 || {mv_t1, mv_g12, mv_t2, mv_g21} !== {8'd10, 8'd3, 8'd10, 8'd3}) begin
      fails++;
      $display("FAIL overlap_recover: got %0d pulses %0d/%0d/%0d/%0d expected 1 pulse 10/3/10/3",
               mv_cnt - base, mv_t1, mv_g12, mv_t2, mv_g21);
    end
    tests++;
    if ({ovl_err, locked} !== 2'b11) begin
      fails++;
      $display("FAIL overlap_sticky: got ovl=%b locked=%b expected ovl=1 locked=1",
               ovl_err, locked);
    end
    pulse_clear();
    tests++;
    if ({ovl_err, locked} !== 2'b01) begin
      fails++;
      $display("FAIL clear_err: got ovl=%b locked=%b expected ovl=0 locked=1", ovl_err, locked);
    end
  endtask

  task automatic test_min_gap();
    period(10, 2, 10, 2);
    base = mv_cnt;
    hold(1'b1, 1'b0, 5);
    tests++;
    if (mv_cnt - base !== 1 || mv_g12 !== 8'd2 || mv_g21 !== 8'd2) begin
      fails++;
      $display("FAIL min_gap_meas: got %0d pulses g12=%0d g21=%0d expected 1 pulse 2/2",
               mv_cnt - base, mv_g12, mv_g21);
    end
    tests++;
    if ({gap_err, locked} !== 2'b01) begin
      fails++;
      $display("FAIL min_gap_status: got gap=%b locked=%b expected gap=0 locked=1",
               gap_err, locked);
    end
    finish_period();
  endtask

  task automatic test_gap1();
    period(10, 1, 10, 3);
    base = mv_cnt;
    hold(1'b1, 1'b0, 5);
    tests++;
    if (mv_cnt - base !== 1 || mv_g12 !== 8'd1 || mv_t1 !== 8'd10) begin
      fails++;
      $display("FAIL gap1_meas: got %0d pulses t1=%0d g12=%0d expected 1 pulse t1=10 g12=1",
               mv_cnt - base, mv_t1, mv_g12);
    end
    tests++;
    if ({gap_err, locked} !== 2'b10) begin
      fails++;
      $display("FAIL gap1_status: got gap=%b locked=%b expected gap=1 locked=0",
               gap_err, locked);
    end
    finish_period();
    pulse_clear();
  endtask

  task automatic test_zero_gap();
    hold(1'b1, 1'b0, 10);
    base = mv_cnt;
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b0, 5);
    tests++;
    if (mv_cnt - base !== 1 || mv_g12 !== 8'd0 || mv_t2 !== 8'd10) begin
      fails++;
      $display("FAIL zero_gap_meas: got %0d pulses g12=%0d t2=%0d expected 1 pulse g12=0 t2=10",
               mv_cnt - base, mv_g12, mv_t2);
    end
    tests++;
    if ({gap_err, ovl_err} !== 2'b10) begin
      fails++;
      $display("FAIL zero_gap_status: got gap=%b ovl=%b expected gap=1 ovl=0", gap_err, ovl_err);
    end
    finish_period();
    pulse_clear();
  endtask

  task automatic test_seq();
    hold(1'b1, 1'b0, 10);
    base = mv_cnt;
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 3);
    tests++;
    if ({seq_err, locked} !== 2'b10 || mv_cnt - base !== 0) begin
      fails++;
      $display("FAIL seq_detect: got seq=%b locked=%b pulses=%0d expected seq=1 locked=0 pulses=0",
               seq_err, locked, mv_cnt - base);
    end
    repeat (2) period(10, 3, 10, 3);
    tests++;
    if (mv_cnt - base !== 1 || {mv_t1, mv_g12, mv_t2, mv_g21} !== {8'd10, 8'd3, 8'd10, 8'd3}
        || locked !== 1'b1) begin
      fails++;
      $display("FAIL seq_recover: got %0d pulses %0d/%0d/%0d/%0d locked=%b expected 1 10/3/10/3 1",
               mv_cnt - base, mv_t1, mv_g12, mv_t2, mv_g21, locked);
    end
    pulse_clear();
  endtask

  task automatic test_stall_reset();
    hold(1'b1, 1'b0, 200);
    tests++;
    if (stall_err !== 1'b0) begin
      fails++;
      $display("FAIL stall_early: got %b expected 0", stall_err);
    end
    hold(1'b1, 1'b0, 100);
    tests++;
    if ({stall_err, locked} !== 2'b10) begin
      fails++;
      $display("FAIL stall_flag: got stall=%b locked=%b expected stall=1 locked=0",
               stall_err, locked);
    end
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b0, 5);
    hold(1'b0, 1'b0, 1);
    tests++;
    if (clk_rec !== 1'b1) begin
      fails++;
      $display("FAIL clk_rec_active: got %b expected 1", clk_rec);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({clk_rec, meas_valid, locked, ovl_err, seq_err, gap_err, stall_err} !== 7'b0 ||
        {t_phi1, t_gap12, t_phi2, t_gap21} !== 32'h0) begin
      fails++;
      $display("FAIL midreset: got flags=%b meas=%h expected all 0",
               {clk_rec, meas_valid, locked, ovl_err, seq_err, gap_err, stall_err},
               {t_phi1, t_gap12, t_phi2, t_gap21});
    end
    rst_n = 1'b1;
    base = mv_cnt;
    hold(1'b0, 1'b0, 2);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 3);
    period(10, 3, 10, 3);
    tests++;
    if (locked !== 1'b0 || mv_cnt - base !== 0) begin
      fails++;
      $display("FAIL relock_early: got locked=%b pulses=%0d expected 0 0", locked, mv_cnt - base);
    end
    hold(1'b1, 1'b0, 5);
    tests++;
    if (locked !== 1'b1 || mv_cnt - base !== 1 ||
        {mv_t1, mv_g12, mv_t2, mv_g21} !== {8'd10, 8'd3, 8'd10, 8'd3}) begin
      fails++;
      $display("FAIL relock: got locked=%b pulses=%0d %0d/%0d/%0d/%0d expected 1 1 10/3/10/3",
               locked, mv_cnt - base, mv_t1, mv_g12, mv_t2, mv_g21);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_clean();
    test_overlap();
    test_min_gap();
    test_gap1();
    test_zero_gap();
    test_seq();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
